// File: rtl/seg_disp_pkg.sv
// Shared constants for the multiplexed seven-segment scanner:
// hex-to-segment table (active-low, bit6 = g ... bit0 = a) and counter sizing.
package seg_disp_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // Minimum width 1 so single-digit / trivial counters still get a real register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low seven-segment pattern (bit6 = g ... bit0 = a).
module seg_hex_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode hex display scanner with per-slot blanking,
// leading-zero suppression and frame-synchronous (tear-free) value updates.
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DIV    = 65536,
    parameter int BLANK  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lz_suppress,
    input  logic                  enable,
    output logic [DIGITS-1:0]     sel_seg,
    output logic [6:0]            seg7,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int SLOT_W = cnt_width(DIV);
    localparam int IDX_W  = cnt_width(DIGITS);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] shadow_nib;
    logic [DIGITS-1:0]   shadow_dp;
    logic                pending;
    logic [4*DIGITS-1:0] active_nib;
    logic [DIGITS-1:0]   active_dp;
    logic [SLOT_W-1:0]   slot_cnt;
    logic [IDX_W-1:0]    dig_idx;

    logic                slot_last;
    logic                frame_end;
    logic [3:0]          nib_arr [DIGITS];
    logic [3:0]          cur_nib;
    logic [6:0]          dec_seg;
    logic [DIGITS-1:0]   lz_mask;
    logic                upper_zero;
    logic [DIGITS-1:0]   sel_drive;

    assign slot_last = (slot_cnt == SLOT_LAST);
    assign frame_end = enable && slot_last && (dig_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_nib <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                shadow_nib <= din;
                shadow_dp  <= dp_in;
            end
            // A load on the boundary goes straight to active, so nothing stays pending.
            if (frame_end)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_nib <= '0;
            active_dp  <= '0;
        end else if (frame_end) begin
            if (load) begin
                active_nib <= din;
                active_dp  <= dp_in;
            end else if (pending) begin
                active_nib <= shadow_nib;
                active_dp  <= shadow_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (!enable) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        assign nib_arr[g] = active_nib[4*g +: 4];
    end

    assign cur_nib = nib_arr[dig_idx];

    seg_hex_decode u_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // lz_mask[i] set when nibbles i..DIGITS-1 are all zero; digit 0 always shown.
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (active_nib[4*i +: 4] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    end

    assign sel_drive = ~(DIGITS'(1) << dig_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_seg    <= '1;
            seg7       <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (enable && (slot_cnt >= BLANK_END)) begin
                sel_seg <= sel_drive;
                seg7    <= (lz_suppress && lz_mask[dig_idx]) ? SEG_OFF : dec_seg;
                dp      <= ~active_dp[dig_idx];
            end else begin
                sel_seg <= '1;
                seg7    <= SEG_OFF;
                dp      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: per-cycle reference model driven by
// a free-running frame-time counter, table vectors and multi-cycle corner cases.
module tb_seg_scan_display;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_suppress = 1'b0;
    logic        enable = 1'b1;
    logic [3:0]  sel_seg;
    logic [6:0]  seg7;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_display #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .dp_in       (dp_in),
        .load        (load),
        .lz_suppress (lz_suppress),
        .enable      (enable),
        .sel_seg     (sel_seg),
        .seg7        (seg7),
        .dp          (dp),
        .frame_done  (frame_done)
    );

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Reference model: t counts enabled cycles since the scan (re)started.
    int          t;
    int          m_pos, m_dig, m_slot;
    logic [15:0] m_shadow, m_active;
    logic [3:0]  m_sdp, m_adp;
    bit          m_pend;
    logic [3:0]  e_sel;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;
    logic [3:0]  m_nib;
    bit          m_bound;

    always @(posedge clk or negedge rst_n) begin
        e_sel = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        if (!rst_n) begin
            t = 0; m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0; m_pend = 0;
        end else if (enable) begin
            m_pos  = t % FRAME;
            m_dig  = m_pos / DIV;
            m_slot = m_pos % DIV;
            if (m_slot >= BLANK) begin
                m_nib = 4'(m_active >> (4 * m_dig));
                e_sel = ~(4'b0001 << m_dig);
                e_seg = (lz_suppress && m_dig >= 1 && (m_active >> (4 * m_dig)) == 16'h0)
                        ? 7'h7F : ref_seg(m_nib);
                e_dp  = ~m_adp[m_dig];
            end
            m_bound = (m_pos == FRAME - 1);
            e_fd    = m_bound;
            if (m_bound) begin
                if (load) begin m_active = din; m_adp = dp_in; end
                else if (m_pend) begin m_active = m_shadow; m_adp = m_sdp; end
                m_pend = 0;
            end else if (load) begin
                m_pend = 1;
            end
            if (load) begin m_shadow = din; m_sdp = dp_in; end
            t = t + 1;
        end else begin
            t = 0;
            if (load) begin m_shadow = din; m_sdp = dp_in; m_pend = 1; end
        end
        #1;
        checks++;
        if ({sel_seg, seg7, dp, frame_done} !== {e_sel, e_seg, e_dp, e_fd}) begin
            errors++;
            $display("FAIL cycle_model t=%0d: got sel=%b seg=%b dp=%b fd=%b, need sel=%b seg=%b dp=%b fd=%b",
                     t, sel_seg, seg7, dp, frame_done, e_sel, e_seg, e_dp, e_fd);
        end
    end

    // Record the last DRIVE outputs seen on each digit.
    logic [6:0] obs_seg [DIGITS];
    logic       obs_dp  [DIGITS];
    bit         obs_seen[DIGITS];

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < DIGITS; i++)
            if (sel_seg == ~(4'b0001 << i)) begin
                obs_seg[i] = seg7; obs_dp[i] = dp; obs_seen[i] = 1;
            end
    end

    task automatic clear_obs();
        for (int i = 0; i < DIGITS; i++) obs_seen[i] = 0;
    endtask

    task automatic wait_frame(input string tag);
        bit got = 0;
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            @(posedge clk); #2;
            if (frame_done) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: frame_done got 0 within %0d cycles, need 1", tag, 2 * FRAME);
        end
    endtask

    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (!obs_seen[d] || obs_seg[d] !== segs[7*d +: 7] || obs_dp[d] !== dps[d]) begin
                errors++;
                $display("FAIL %s digit%0d: got seen=%0d seg=%b dp=%b, need seg=%b dp=%b",
                         tag, d, obs_seen[d], obs_seg[d], obs_dp[d], segs[7*d +: 7], dps[d]);
            end
        end
    endtask

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dps;
        logic        lz;
        logic [27:0] segs;     // {d3, d2, d1, d0}
        logic [3:0]  dp_pins;  // expected active-low dp per digit
    } vec_t;

    vec_t vecs[7];

    task automatic load_value(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        din = v; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    int n;

    initial begin
        vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111};
        vecs[1] = '{16'h0007, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1111000}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111};
        vecs[3] = '{16'h3A50, 4'b0100, 1'b1, {7'b0110000, 7'b0001000, 7'b0010010, 7'b1000000}, 4'b1011};
        vecs[4] = '{16'h0B00, 4'b0000, 1'b1, {7'h7F, 7'b0000011, 7'b1000000, 7'b1000000}, 4'b1111};
        vecs[5] = '{16'h0B00, 4'b0000, 1'b0, {7'b1000000, 7'b0000011, 7'b1000000, 7'b1000000}, 4'b1111};
        vecs[6] = '{16'hC8D6, 4'b1001, 1'b0, {7'b1000110, 7'b0000000, 7'b0100001, 7'b0000010}, 4'b0110};

        repeat (3) @(negedge clk);
        checks++;
        if ({sel_seg, seg7, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %b %b %b %b, need 1111 1111111 1 0", sel_seg, seg7, dp, frame_done);
        end
        rst_n = 1'b1;

        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2; n++;
            if (sel_seg != 4'hF) break;
        end
        checks++;
        if (n != BLANK + 1 || sel_seg !== 4'b1110 || seg7 !== 7'b1000000) begin
            errors++;
            $display("FAIL first_drive: got cycle=%0d sel=%b seg=%b, need cycle=%0d sel=1110 seg=1000000",
                     n, sel_seg, seg7, BLANK + 1);
        end

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            lz_suppress = vecs[v].lz;
            load_value(vecs[v].value, vecs[v].dps);
            wait_frame("vec_boundary");
            clear_obs();
            wait_frame("vec_frame");
            check_frame($sformatf("vec%0d", v), vecs[v].segs, vecs[v].dp_pins);
        end

        // Two loads in one frame: current frame untouched, last one wins next frame.
        lz_suppress = 1'b0;
        load_value(16'h4444, 4'b0000);
        wait_frame("sync4");
        wait_frame("show4");
        clear_obs();
        repeat (3) @(negedge clk);
        load_value(16'h1111, 4'b0000);
        repeat (5) @(negedge clk);
        load_value(16'h2222, 4'b0000);
        wait_frame("hold_frame");
        check_frame("no_tear", {4{7'b0011001}}, 4'b1111);
        clear_obs();
        wait_frame("last_wins");
        check_frame("last_wins", {4{7'b0100100}}, 4'b1111);

        // Load landing exactly on the boundary cycle.
        @(negedge clk);
        repeat (FRAME - 1) @(negedge clk);
        din = 16'h9999; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        #2;
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL boundary_align: frame_done got %b, need 1", frame_done);
        end
        clear_obs();
        wait_frame("coincident");
        check_frame("coincident", {4{7'b0010000}}, 4'b1111);

        // Enable drop mid-slot, then restart.
        repeat (DIV + BLANK + 2) @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #2;
        checks++;
        if ({sel_seg, seg7, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL enable_off: got %b %b %b, need 1111 1111111 1", sel_seg, seg7, dp);
        end
        n = 0;
        repeat (FRAME + 4) begin
            @(posedge clk); #2;
            if (frame_done || sel_seg != 4'hF) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL enable_dark: got %0d active cycles, need 0", n);
        end
        @(negedge clk);
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2; n++;
            if (sel_seg != 4'hF) break;
        end
        checks++;
        if (n != BLANK + 1 || sel_seg !== 4'b1110) begin
            errors++;
            $display("FAIL reenable: got cycle=%0d sel=%b, need cycle=%0d sel=1110", n, sel_seg, BLANK + 1);
        end

        // Async reset mid-frame with a pending load.
        wait_frame("pre_reset");
        load_value(16'h5678, 4'b1111);
        repeat (DIV + 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel_seg, seg7, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %b %b %b %b, need 1111 1111111 1 0", sel_seg, seg7, dp, frame_done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        wait_frame("post_reset1");
        check_frame("post_reset1", {4{7'b1000000}}, 4'b1111);
        clear_obs();
        wait_frame("post_reset2");
        check_frame("post_reset2", {4{7'b1000000}}, 4'b1111);

        // Randomized traffic, checked every cycle by the reference model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            load   = ($urandom_range(0, 15) == 0);
            din    = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in  = 4'($urandom);
            if ($urandom_range(0, 60) == 0) lz_suppress = ~lz_suppress;
            enable = ($urandom_range(0, 150) != 0);
        end
        @(negedge clk);
        load = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
